// File: rtl/gol_pkg.sv
// Shared Game-of-Life constants and the generation scheduler state encoding.
package gol_pkg;

    localparam int X_SIZE  = 1280;
    localparam int Y_SIZE  = 720;
    localparam int Y_WIDTH = $clog2(Y_SIZE);
    localparam int GEN_W   = 32;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;
    localparam logic [1:0] ST_SWAP_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        RUN       = ST_RUN,
        DRAIN     = ST_DRAIN,
        SWAP_WAIT = ST_SWAP_WAIT
    } gen_state_e;

endpackage

// File: rtl/generation_scheduler_wb_tracker.sv
// Counts result-row write-backs for the generation in flight and flags unexpected ones.
module wb_tracker #(
    parameter int Y_SIZE = gol_pkg::Y_SIZE,
    parameter int CNT_W  = $clog2(Y_SIZE + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic cnt_en_i,
    input  logic wb_done_i,
    output logic all_done_o,
    output logic overrun_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Y_SIZE);
    localparam logic [CNT_W:0]   TARGET  = (CNT_W + 1)'(Y_SIZE);

    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
    logic             overrun_q, overrun_d;
    logic             full;

    assign full = (wb_cnt_q == CNT_MAX);

    // Includes this cycle's pulse so the last write-back and frame_end can coincide.
    assign all_done_o = ({1'b0, wb_cnt_q} + {{CNT_W{1'b0}}, wb_done_i}) >= TARGET;
    assign overrun_o  = overrun_q;

    always_comb begin
        wb_cnt_d  = wb_cnt_q;
        overrun_d = overrun_q;
        if (wb_done_i && (!cnt_en_i || full))
            overrun_d = 1'b1;
        if (clr_i)
            wb_cnt_d = '0;
        else if (wb_done_i && cnt_en_i && !full)
            wb_cnt_d = wb_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_cnt_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wb_cnt_q  <= wb_cnt_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: rtl/generation_scheduler.sv
// Runs one Game-of-Life generation at a time over the ping-pong banks and flips
// the displayed bank only on a video frame boundary.
module generation_scheduler #(
    parameter int Y_SIZE  = gol_pkg::Y_SIZE,
    parameter int Y_WIDTH = $clog2(Y_SIZE),
    parameter int GEN_W   = gol_pkg::GEN_W
) (
    input  logic               out_stream_aclk,
    input  logic               periph_reset,
    input  logic               init_done,
    input  logic               pause,
    input  logic               step,
    input  logic               frame_end,
    input  logic               row_ready,
    input  logic               wb_done,
    output logic               row_valid,
    output logic [Y_WIDTH-1:0] calc_row,
    output logic               calc_flag,
    output logic               src_bank,
    output logic [GEN_W-1:0]   gen_count,
    output logic               wb_overrun
);

    import gol_pkg::gen_state_e;
    import gol_pkg::IDLE;
    import gol_pkg::RUN;
    import gol_pkg::DRAIN;
    import gol_pkg::SWAP_WAIT;

    localparam logic [Y_WIDTH-1:0] LAST_ROW = Y_WIDTH'(Y_SIZE - 1);

    gen_state_e         state_q;
    logic               row_valid_q;
    logic [Y_WIDTH-1:0] calc_row_q;
    logic               calc_flag_q;
    logic               src_bank_q;
    logic [GEN_W-1:0]   gen_count_q;
    logic               step_pend_q;

    logic start;
    logic all_done;

    assign start = (state_q == IDLE) && init_done && (!pause || step || step_pend_q);

    wb_tracker #(.Y_SIZE(Y_SIZE)) u_wb_tracker (
        .clk_i      (out_stream_aclk),
        .rst_i      (periph_reset),
        .clr_i      (start),
        .cnt_en_i   (calc_flag_q),
        .wb_done_i  (wb_done),
        .all_done_o (all_done),
        .overrun_o  (wb_overrun)
    );

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q     <= IDLE;
            row_valid_q <= 1'b0;
            calc_row_q  <= '0;
            calc_flag_q <= 1'b0;
            src_bank_q  <= 1'b0;
            gen_count_q <= '0;
            step_pend_q <= 1'b0;
        end else begin
            // A step while running is remembered so the next generation follows.
            if (step && pause && (state_q != IDLE))
                step_pend_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        row_valid_q <= 1'b1;
                        calc_flag_q <= 1'b1;
                        calc_row_q  <= '0;
                        step_pend_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (row_ready) begin
                        if (calc_row_q == LAST_ROW) begin
                            state_q     <= DRAIN;
                            row_valid_q <= 1'b0;
                            calc_row_q  <= '0;
                        end else begin
                            calc_row_q  <= calc_row_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (all_done) begin
                        calc_flag_q <= 1'b0;
                        if (frame_end) begin
                            src_bank_q  <= ~src_bank_q;
                            gen_count_q <= gen_count_q + 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q     <= SWAP_WAIT;
                        end
                    end
                end
                SWAP_WAIT: begin
                    if (frame_end) begin
                        src_bank_q  <= ~src_bank_q;
                        gen_count_q <= gen_count_q + 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign row_valid = row_valid_q;
    assign calc_row  = calc_row_q;
    assign calc_flag = calc_flag_q;
    assign src_bank  = src_bank_q;
    assign gen_count = gen_count_q;

endmodule

// File: tb/tb_generation_scheduler.sv
// Scoreboard bench for generation_scheduler: expected rows queued per generation,
// popped on each row handshake; bank/generation/overrun modelled alongside.
module tb_generation_scheduler;

    localparam int Y_SIZE  = 720;
    localparam int Y_WIDTH = $clog2(Y_SIZE);
    localparam int GEN_W   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               init_done, pause, step, frame_end, row_ready, wb_done;
    logic               row_valid, calc_flag, src_bank, wb_overrun;
    logic [Y_WIDTH-1:0] calc_row;
    logic [GEN_W-1:0]   gen_count;

    generation_scheduler #(.Y_SIZE(Y_SIZE), .Y_WIDTH(Y_WIDTH), .GEN_W(GEN_W)) dut (
        .out_stream_aclk (clk),
        .periph_reset    (rst),
        .init_done       (init_done),
        .pause           (pause),
        .step            (step),
        .frame_end       (frame_end),
        .row_ready       (row_ready),
        .wb_done         (wb_done),
        .row_valid       (row_valid),
        .calc_row        (calc_row),
        .calc_flag       (calc_flag),
        .src_bank        (src_bank),
        .gen_count       (gen_count),
        .wb_overrun      (wb_overrun)
    );

    always #5 clk = ~clk;

    int       n_vec = 0, n_err = 0;
    int       cyc_n = 0, hs_cnt = 0, n_extra = 0, wb_seen = 0;
    int       rr_mode = 0;
    bit       fe_on_last = 0;
    logic [3:0] wb_pipe = '0;
    int       exp_q[$];
    logic     exp_bank = 1'b0;
    logic [GEN_W-1:0] exp_gen = '0;
    logic     exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic push_gen();
        for (int r = 0; r < Y_SIZE; r++) exp_q.push_back(r);
    endtask

    // One clock: at the falling edge drive inputs for the next rising edge and
    // score the row handshake that edge will perform.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        step      = 1'b0;
        frame_end = 1'b0;
        row_ready = (rr_mode == 0) ? 1'b1 : ((cyc_n % 3) == 0);
        if (row_valid && row_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) n_extra++;
            else chk("row", 64'(calc_row), 64'(exp_q.pop_front()));
        end
        wb_pipe = {wb_pipe[2:0], row_valid & row_ready};
        wb_done = wb_pipe[3];
        if (wb_done) wb_seen++;
        if (wb_done && fe_on_last && wb_seen == Y_SIZE) frame_end = 1'b1;
    endtask

    task automatic wait_start(input string tag, output int n);
        n = 0;
        do begin cyc(); n++; end while (!calc_flag && n < 50);
        chk(tag, 64'(calc_flag), 64'd1);
    endtask

    task automatic wait_gen_end(input string tag, output int vcyc);
        int n = 0;
        vcyc = 0;
        while (calc_flag && n < 5000) begin
            if (row_valid) vcyc++;
            cyc();
            n++;
        end
        chk(tag, 64'(calc_flag), 64'd0);
    endtask

    task automatic do_swap(input string tag);
        frame_end = 1'b1;
        cyc();
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 1'b1;
        chk({tag, "_bank"}, 64'(src_bank), 64'(exp_bank));
        chk({tag, "_gen"}, 64'(gen_count), 64'(exp_gen));
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_row_valid"}, 64'(row_valid), 64'(0));
        chk({tag, "_calc_row"},  64'(calc_row),  64'(0));
        chk({tag, "_calc_flag"}, 64'(calc_flag), 64'(0));
        chk({tag, "_src_bank"},  64'(src_bank),  64'(0));
        chk({tag, "_gen_count"}, 64'(gen_count), 64'(0));
        chk({tag, "_overrun"},   64'(wb_overrun), 64'(0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v, h0;
        rst = 1'b1; init_done = 1'b0; pause = 1'b0; step = 1'b0;
        frame_end = 1'b0; row_ready = 1'b0; wb_done = 1'b0;
        #23;
        chk_outputs("reset");
        cyc(); cyc();
        rst = 1'b0;

        // Basic generation, row_ready always high, swap on a later frame_end.
        push_gen();
        hs_cnt = 0;
        init_done = 1'b1;
        wait_start("g1_start", n);
        chk("g1_latency", 64'(n), 64'd1);
        init_done = 1'b0;
        wait_gen_end("g1_end", v);
        chk("g1_run_cycles", 64'(v), 64'(Y_SIZE));
        chk("g1_hs", 64'(hs_cnt), 64'(Y_SIZE));
        repeat (3) cyc();
        chk("g1_bank_before", 64'(src_bank), 64'(exp_bank));
        chk("g1_overrun", 64'(wb_overrun), 64'(exp_ovr));
        do_swap("g1");

        // Back-pressured generation: ready one cycle in three.
        rr_mode = 1;
        push_gen();
        hs_cnt = 0;
        init_done = 1'b1;
        wait_start("g2_start", n);
        init_done = 1'b0;
        wait_gen_end("g2_end", v);
        chk("g2_hs", 64'(hs_cnt), 64'(Y_SIZE));
        chk("g2_q_empty", 64'(exp_q.size()), 64'd0);
        do_swap("g2");
        rr_mode = 0;

        // Paused: two steps 5 cycles apart give exactly two generations.
        pause = 1'b1;
        init_done = 1'b1;
        repeat (5) cyc();
        chk("pause_idle", 64'(calc_flag), 64'd0);
        push_gen(); push_gen();
        step = 1'b1;
        wait_start("s1_start", n);
        repeat (4) cyc();
        step = 1'b1;
        wait_gen_end("s1_end", v);
        do_swap("s1");
        wait_start("s2_start", n);
        wait_gen_end("s2_end", v);
        do_swap("s2");
        repeat (20) cyc();
        chk("s_idle_flag", 64'(calc_flag), 64'd0);
        chk("s_idle_valid", 64'(row_valid), 64'd0);
        chk("s_gen_hold", 64'(gen_count), 64'(exp_gen));
        chk("s_q_empty", 64'(exp_q.size()), 64'd0);

        // Last write-back coincides with frame_end: swap without SWAP_WAIT.
        init_done = 1'b0;
        pause = 1'b0;
        push_gen();
        wb_seen = 0;
        fe_on_last = 1'b1;
        init_done = 1'b1;
        wait_start("c_start", n);
        init_done = 1'b0;
        wait_gen_end("c_end", v);
        fe_on_last = 1'b0;
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 1'b1;
        chk("c_bank", 64'(src_bank), 64'(exp_bank));
        chk("c_gen", 64'(gen_count), 64'(exp_gen));
        repeat (10) cyc();
        chk("c_gen_once", 64'(gen_count), 64'(exp_gen));
        chk("c_bank_hold", 64'(src_bank), 64'(exp_bank));

        // Spurious write-back while waiting for the frame boundary.
        push_gen();
        init_done = 1'b1;
        wait_start("o_start", n);
        init_done = 1'b0;
        wait_gen_end("o_end", v);
        chk("o_pre", 64'(wb_overrun), 64'(exp_ovr));
        wb_done = 1'b1;
        cyc();
        exp_ovr = 1'b1;
        chk("o_set", 64'(wb_overrun), 64'(exp_ovr));
        chk("o_bank", 64'(src_bank), 64'(exp_bank));
        chk("o_gen", 64'(gen_count), 64'(exp_gen));
        do_swap("o");
        chk("o_sticky", 64'(wb_overrun), 64'(exp_ovr));

        // Reset in the middle of row 300.
        push_gen();
        init_done = 1'b1;
        wait_start("r_start", n);
        h0 = 0;
        while (calc_row != 300 && h0 < 2000) begin cyc(); h0++; end
        chk("r_reach300", 64'(calc_row), 64'd300);
        rst = 1'b1;
        #1;
        chk_outputs("r_async");
        exp_q.delete();
        wb_pipe = '0;
        wb_done = 1'b0;
        exp_bank = 1'b0; exp_gen = '0; exp_ovr = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        push_gen();
        hs_cnt = 0;
        wait_start("r2_start", n);
        chk("r2_bank", 64'(src_bank), 64'(exp_bank));
        chk("r2_first_row", 64'(calc_row), 64'd0);
        init_done = 1'b0;
        wait_gen_end("r2_end", v);
        chk("r2_hs", 64'(hs_cnt), 64'(Y_SIZE));
        do_swap("r2");
        chk("r2_overrun", 64'(wb_overrun), 64'(exp_ovr));

        chk("extra_hs", 64'(n_extra), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
